// File: rtl/fp_result_queue_if.sv
// Handshake bundle between the FP ALU, the result queue and its consumer.
// The queue connects through the slave modport; the surrounding logic uses master.
interface fp_result_queue_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0]             in_result;
    logic [4:0]               in_flags;
    logic                     out_valid;
    logic                     out_ready;
    logic [N-1:0]             out_result;
    logic [4:0]               out_flags;
    logic                     sticky_clr;
    logic [4:0]               sticky_flags;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_result, in_flags, out_ready, sticky_clr,
        input  in_ready, out_valid, out_result, out_flags, sticky_flags, count
    );

    modport slave (
        input  in_valid, in_result, in_flags, out_ready, sticky_clr,
        output in_ready, out_valid, out_result, out_flags, sticky_flags, count
    );
endinterface

// File: rtl/fp_result_queue.sv
// FIFO of {result, exception flags} downstream of the FP ALU, with back-pressure
// on the ALU and a sticky OR of the flags of every accepted result.
module fp_result_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    fp_result_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [N+4:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [4:0]    sticky_q;
    logic [N+4:0]  head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Full/empty come from the registered count only, so in_ready never sees out_ready.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A clear colliding with a push keeps the pushed flags.
            sticky_q <= (bus.sticky_clr ? 5'b0 : sticky_q) | (push ? bus.in_flags : 5'b0);
        end
    end

    // Storage is not reset; the outputs are gated to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_result, bus.in_flags};
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.in_ready     = !full;
    assign bus.out_valid    = !empty;
    assign bus.out_result   = empty ? '0 : head[N+4:5];
    assign bus.out_flags    = empty ? 5'b0 : head[4:0];
    assign bus.sticky_flags = sticky_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_fp_result_queue.sv
// Bench for fp_result_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the FIFO and sticky flags.
module tb_fp_result_queue;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_result_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();
    fp_result_queue #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [N+4:0] mq[$];
    logic [4:0]   msticky;
    logic [N-1:0] popped[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N+4:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("out_result", 64'(bus.out_result), 64'(h[N+4:5]));
        chk("out_flags", 64'(bus.out_flags), 64'(h[4:0]));
        chk("sticky", 64'(bus.sticky_flags), 64'(msticky));
    endtask

    // One clock: decide the handshakes from current inputs and model, step, then check.
    task automatic cycle();
        bit           push, pop, clr;
        logic [N-1:0] res;
        logic [4:0]   fl;
        push = bus.in_valid && (mq.size() < DEPTH);
        pop  = bus.out_ready && (mq.size() > 0);
        clr  = bus.sticky_clr;
        res  = bus.in_result;
        fl   = bus.in_flags;
        if (pop) popped.push_back(bus.out_result);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({res, fl});
        msticky = (clr ? 5'b0 : msticky) | (push ? fl : 5'b0);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [N-1:0] r, input logic [4:0] f,
                         input bit ordy, input bit clr);
        bus.in_valid   = v;
        bus.in_result  = r;
        bus.in_flags   = f;
        bus.out_ready  = ordy;
        bus.sticky_clr = clr;
    endtask

    initial begin
        msticky = '0;
        drive(0, '0, '0, 0, 0);
        rst = 1'b1;
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Single pass-through.
        drive(1, 32'h3F80_0000, 5'b00001, 1, 0);
        cycle();
        chk("pt_valid", 64'(bus.out_valid), 64'd1);
        chk("pt_result", 64'(bus.out_result), 64'h3F80_0000);
        chk("pt_flags", 64'(bus.out_flags), 64'd1);
        drive(0, '0, '0, 1, 0);
        cycle();
        chk("pt_count", 64'(bus.count), 64'd0);
        chk("pt_sticky", 64'(bus.sticky_flags), 64'd1);

        // Fill, back-pressure, full with push+pop, then drain.
        popped.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(1, N'(i), 5'b0, 0, 0);
            cycle();
        end
        drive(1, 32'h5, 5'b0, 0, 0);
        cycle();
        cycle();
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        drive(1, 32'h5, 5'b0, 1, 0);
        cycle();
        chk("full_pushpop_count", 64'(bus.count), 64'd3);
        chk("full_pushpop_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_npop", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            chk("bp_order", 64'(popped[i]), 64'(i + 1));

        // Wrap-around with occupancy held at 1.
        popped.delete();
        drive(1, 32'hA0, 5'b0, 0, 0);
        cycle();
        for (int i = 1; i < 10; i++) begin
            drive(1, N'(32'hA0 + i), 5'b0, 1, 0);
            cycle();
            chk("wrap_count", 64'(bus.count), 64'd1);
        end
        drive(0, '0, '0, 1, 0);
        cycle();
        cycle();
        chk("wrap_npop", 64'(popped.size()), 64'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk("wrap_order", 64'(popped[i]), 64'(32'hA0 + i));

        // Sticky clear colliding with a push.
        drive(0, '0, '0, 1, 1);
        cycle();
        chk("sticky_clr", 64'(bus.sticky_flags), 64'd0);
        drive(1, 32'h11, 5'b10000, 1, 0);
        cycle();
        chk("sticky_set", 64'(bus.sticky_flags), 64'b10000);
        drive(1, 32'h22, 5'b00100, 1, 1);
        cycle();
        chk("sticky_collide", 64'(bus.sticky_flags), 64'b00100);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 3) != 0), N'($urandom), 5'($urandom),
                  bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
            cycle();
        end

        // Reset between clock edges with three entries held.
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 5; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, N'(32'hC0 + i), 5'b01000, 0, 0);
            cycle();
        end
        drive(0, '0, '0, 0, 0);
        chk("pre_rst_count", 64'(bus.count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        msticky = '0;
        check_outputs();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h7, 5'b0, 0, 0);
        cycle();
        chk("post_rst_result", 64'(bus.out_result), 64'h7);
        chk("post_rst_count", 64'(bus.count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_result_queue.md
# fp_result_queue

Result buffer sitting directly downstream of the floating-point ALU. It accepts each completed result and its 5 exception flags over a valid/ready handshake, and holds them in a small FIFO. It drives the ALU's `ready_in`, so a slow consumer back-pressures the arithmetic pipeline instead of losing results. It also keeps a sticky exception-flag register: the OR of the flags of every accepted result since the last clear.

## Interface
- `N`, default 32: result word width (sign + exponent + mantissa).
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: the ALU presents a result (wired from the ALU's `valid_out`).
- `in_ready`  out  1: the queue can accept; wired to the ALU's `ready_in`.
- `in_result`  in  N: result word.
- `in_flags`  in  5: exception flags, bit order {invalid, div-by-zero, overflow, underflow, inexact}.
- `out_valid`  out  1: the head entry is available.
- `out_ready`  in  1: the consumer takes the head entry.
- `out_result`  out  N: head result word.
- `out_flags`  out  5: head entry's flags.
- `sticky_clr`  in  1: clear the sticky flags.
- `sticky_flags`  out  5: accumulated exception flags.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {result, flags}, with write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits.
  - Both pointers wrap modulo DEPTH.
  - Full and empty are decided by `count`, never by pointer comparison.
- Push when `in_valid && in_ready`:
  - write the entry at `wr_ptr`;
  - increment `wr_ptr`.
- Pop when `out_valid && out_ready`:
  - increment `rd_ptr`.
- Count update:
  - `count` += 1 on a push alone;
  - `count` -= 1 on a pop alone;
  - `count` is unchanged on a simultaneous push and pop.
- `in_ready = (count != DEPTH)`.
  - It depends only on registered state.
  - When full, a same-cycle pop does not open a slot in that cycle.
- `out_valid = (count != 0)`.
- `out_result` / `out_flags` = the entry at `rd_ptr` while `out_valid`; all zeros while empty.
- Push with `in_valid` high while full: no write, no pointer or count change. The producer holds the data, per the handshake rule.
- Pop request (`out_ready`) while empty: ignored.
- Sticky flags: `sticky_next = (sticky_clr ? 0 : sticky_flags) | (push ? in_flags : 0)`.
  - Flags enter the sticky register on push, not on pop.
  - When clear and push coincide, the pushed flags survive.
- Reset (async, any cycle, including mid-transfer):
  - `count`, `wr_ptr`, `rd_ptr` and `sticky_flags` go to 0;
  - all buffered entries are discarded;
  - storage contents need not be cleared, since `out_*` are gated to zero while empty.
- Reset values of outputs:
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `out_result` = 0;
  - `out_flags` = 0;
  - `sticky_flags` = 0;
  - `count` = 0.

## Timing
- Push-to-output latency: one cycle. An entry pushed at edge k is on `out_result` / `out_valid` right after edge k when the queue was empty.
- No combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.
- Sustained throughput: one push and one pop per cycle while 0 < `count` < DEPTH.
- `sticky_flags` and `count` are registered; they reflect a push or pop from the cycle after the edge at which it occurred.
- Reset deassertion: the first push is accepted at the first rising edge with `rst` low.

## Test plan
- Single pass-through:
  - stimulus: push `in_result`=0x3F800000, `in_flags`=5'b00001 with `out_ready`=1;
  - required: `out_valid`=1 with 0x3F800000 / 5'b00001 one cycle later;
  - required: next cycle, `count` returns to 0 and `sticky_flags`=5'b00001.
- Fill and back-pressure:
  - stimulus: hold `out_ready`=0 and push 0x1, 0x2, 0x3, 0x4 (DEPTH=4), then keep `in_valid`=1 with 0x5;
  - required: `count`=4 and `in_ready`=0; 0x5 is not stored;
  - stimulus: then set `out_ready`=1;
  - required: pops return 0x1..0x4 in order, and 0x5 is accepted after `in_ready` rises.
- Full with simultaneous push and pop:
  - stimulus: at `count`=4, assert `in_valid` and `out_ready` in the same cycle;
  - required: pop only; `count`=3.
- Wrap-around:
  - stimulus: push and pop 10 entries 0xA0..0xA9, keeping `count` between 1 and 3;
  - required: output order is exactly 0xA0..0xA9; both pointers have wrapped at least twice.
- Sticky clear collision:
  - stimulus: with `sticky_flags`=5'b10000, assert `sticky_clr` in the same cycle as a push with flags 5'b00100;
  - required: `sticky_flags`=5'b00100.
- Reset mid-operation:
  - stimulus: with `count`=3, assert `rst` between clock edges;
  - required: immediately `out_valid`=0, `out_result`=0, `count`=0, `sticky_flags`=0, `in_ready`=1;
  - required: after release, a pushed 0x7 is the first value out.
